// File: rtl/ice51_loader.sv
// UART program loader for the ice51: receives 8N1 bytes, writes them to code
// memory from address 0 and releases the core reset once MEM_SIZE bytes have landed.
module ice51_loader #(
   parameter int CLKS_PER_BIT = 104,
   parameter int MEM_SIZE     = 1024,
   parameter int ADDR_W       = 10,
   parameter bit PRELOAD      = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_nrst,
   input  logic              i_uart_rx,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [7:0]        o_mem_wdata,
   output logic              o_cpu_nrst,
   output logic              o_done,
   output logic              o_frame_err,
   output logic [2:0]        o_dbg_state
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_SIZE - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      WRITE = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t             state, nxt;
   logic               rx_meta, rx_s;
   logic [CNT_W-1:0]   cnt;
   logic [2:0]         bit_cnt;
   logic [7:0]         shift;
   logic               discard;
   logic [ADDR_W-1:0]  addr;
   logic               mem_we, done, cpu_nrst, frame_err;
   logic [7:0]         wdata;

   logic cnt_clr, cnt_inc, shift_en, ferr_set, disc_set, disc_clr, addr_inc, done_set;

   always_comb begin
      nxt      = state;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      shift_en = 1'b0;
      ferr_set = 1'b0;
      disc_set = 1'b0;
      disc_clr = 1'b0;
      addr_inc = 1'b0;
      done_set = 1'b0;
      case (state)
         IDLE: begin
            if (PRELOAD) begin
               nxt = DONE;
            end else if (!rx_s) begin
               nxt     = START;
               cnt_clr = 1'b1;
            end
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_clr = 1'b1;
               nxt     = rx_s ? IDLE : DATA;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_clr  = 1'b1;
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) nxt = STOP;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         STOP: begin
            // After a bad stop bit the counter stays saturated until the line idles.
            if (cnt == BIT_LAST) begin
               if (rx_s) begin
                  nxt      = discard ? IDLE : WRITE;
                  disc_clr = 1'b1;
               end else if (!discard) begin
                  ferr_set = 1'b1;
                  disc_set = 1'b1;
               end
            end else begin
               cnt_inc = 1'b1;
            end
         end
         WRITE: begin
            addr_inc = 1'b1;
            if (addr == ADDR_LAST) begin
               done_set = 1'b1;
               nxt      = DONE;
            end else begin
               nxt = IDLE;
            end
         end
         DONE:    nxt = DONE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         state     <= IDLE;
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         cnt       <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         discard   <= 1'b0;
         addr      <= '0;
         mem_we    <= 1'b0;
         wdata     <= '0;
         done      <= 1'b0;
         cpu_nrst  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state   <= nxt;
         rx_meta <= i_uart_rx;
         rx_s    <= rx_meta;
         if (cnt_clr)      cnt <= '0;
         else if (cnt_inc) cnt <= cnt + 1'b1;
         if (shift_en) begin
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (disc_set)      discard <= 1'b1;
         else if (disc_clr) discard <= 1'b0;
         if (ferr_set) frame_err <= 1'b1;
         // Strobe and data are registered together so they are aligned with the WRITE state.
         mem_we <= (nxt == WRITE);
         if (nxt == WRITE) wdata <= shift;
         if (addr_inc) addr <= addr + 1'b1;
         if (PRELOAD || done_set) done <= 1'b1;
         cpu_nrst <= PRELOAD ? 1'b1 : done;
      end
   end

   assign o_mem_we    = mem_we;
   assign o_mem_addr  = addr;
   assign o_mem_wdata = wdata;
   assign o_cpu_nrst  = cpu_nrst;
   assign o_done      = done;
   assign o_frame_err = frame_err;
   assign o_dbg_state = state;

endmodule
